// File: rtl/wb_queue.sv
// wb_queue: writeback merge stage with an in-order write queue.
// Merges ALU results, PC-link values and one-cycle-late DRAM load returns onto
// the single register-file write port. When a load return and a non-load
// result collide, the younger one is queued. Upstream is stalled when the
// queue could not absorb a worst-case cycle.
//
// Ports:
//   clk_i, rst_i          core clock, synchronous active-high reset
//   wb_valid_i            retiring instruction presented
//   wb_stall_o            queue cannot accept; upstream holds
//   rd_wr_en_i/sel_i/addr_i  destination write request and source select
//   pc_data_i, alu_data_i    non-load write sources
//   dram_rd_sel_i/addr_i  load type and byte address (captured at issue)
//   dram_rd_data_i        load data, valid the cycle after issue
//   reg_wr_en_o/addr_o/data_o  register-file write port (combinational)
//   q_level_o             queue occupancy
//
// Optional feature: define WB_LOAD_ALIGN_EN to shift load data right by the
// captured byte offset before extension.

module wb_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wb_valid_i,
    output logic                     wb_stall_o,
    input  logic                     rd_wr_en_i,
    input  logic [1:0]               rd_wr_sel_i,
    input  logic [4:0]               rd_wr_addr_i,
    input  logic [XLEN-1:0]          pc_data_i,
    input  logic [XLEN-1:0]          alu_data_i,
    input  logic [2:0]               dram_rd_sel_i,
    input  logic [XLEN-1:0]          dram_rd_addr_i,
    input  logic [XLEN-1:0]          dram_rd_data_i,
    output logic                     reg_wr_en_o,
    output logic [4:0]               reg_wr_addr_o,
    output logic [XLEN-1:0]          reg_wr_data_o,
    output logic [$clog2(DEPTH):0]   q_level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = (XLEN == 64) ? 3 : 2;

    typedef enum logic [1:0] {
        RD_WR_ALU      = 2'd0,
        RD_WR_PC_INC_4 = 2'd1,
        RD_WR_PC_INC_2 = 2'd2,
        RD_WR_DRAM     = 2'd3
    } reg_op_enum;

    typedef enum logic [2:0] {
        DRAM_RD_B  = 3'd0,
        DRAM_RD_H  = 3'd1,
        DRAM_RD_W  = 3'd2,
        DRAM_RD_BU = 3'd3,
        DRAM_RD_HU = 3'd4
    } ram_op_enum;

    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("wb_queue: XLEN must be 32 or 64");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("wb_queue: DEPTH must be a power of two >= 2");
    end

    // queue storage and state
    logic [4:0]      q_addr [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [AW-1:0]   rd_ptr_r, wr_ptr_r;
    logic [CW-1:0]   count_r;

    // load slot captured at issue
    logic            ld_vld_r;
    logic [4:0]      ld_addr_r;
    logic [2:0]      ld_sel_r;

    reg_op_enum      wr_sel;
    logic            wr_ok, new_vld, ld_take, pop, stall_raw;
    logic [XLEN-1:0] new_data, ld_raw, ld_data;
    logic [CW-1:0]   lvl_after;

    logic            emit_vld;
    logic [4:0]      emit_addr;
    logic [XLEN-1:0] emit_data;
    logic            push0_vld, push1_vld;
    logic [4:0]      push0_addr, push1_addr;
    logic [XLEN-1:0] push0_data, push1_data;

    logic            unused_addr;

`ifdef WB_LOAD_ALIGN_EN
    logic [OW-1:0]   ld_off_r;
    assign ld_raw      = dram_rd_data_i >> {ld_off_r, 3'b000};
    assign unused_addr = ^dram_rd_addr_i[XLEN-1:OW];
`else
    assign ld_raw      = dram_rd_data_i;
    assign unused_addr = ^dram_rd_addr_i;
`endif

    // free slots after this cycle's pop and load push must leave room for one new write
    assign pop        = (count_r != '0);
    assign lvl_after  = count_r + CW'(ld_vld_r) - CW'(pop);
    assign stall_raw  = (lvl_after >= CW'(DEPTH));
    assign wb_stall_o = ~rst_i & stall_raw;

    assign wr_sel  = reg_op_enum'(rd_wr_sel_i);
    assign wr_ok   = wb_valid_i & ~wb_stall_o & ~rst_i & rd_wr_en_i & (rd_wr_addr_i != 5'd0);
    assign new_vld = wr_ok & (wr_sel != RD_WR_DRAM);
    assign ld_take = wr_ok & (wr_sel == RD_WR_DRAM);

    // non-load source mux
    always_comb begin
        new_data = '0;
        case (wr_sel)
            RD_WR_ALU:      new_data = alu_data_i;
            RD_WR_PC_INC_4: new_data = pc_data_i + XLEN'(4);
            RD_WR_PC_INC_2: new_data = pc_data_i + XLEN'(2);
            default:        new_data = '0;
        endcase
    end

    // load extension by captured load type
    always_comb begin
        ld_data = '0;
        case (ram_op_enum'(ld_sel_r))
            DRAM_RD_B:  ld_data = XLEN'($signed(ld_raw[7:0]));
            DRAM_RD_H:  ld_data = XLEN'($signed(ld_raw[15:0]));
            DRAM_RD_W:  ld_data = XLEN'($signed(ld_raw[31:0]));
            DRAM_RD_BU: ld_data = XLEN'(ld_raw[7:0]);
            DRAM_RD_HU: ld_data = XLEN'(ld_raw[15:0]);
            default:    ld_data = '0;
        endcase
    end

    // emit/enqueue priority: queue head, else load return, else new result
    always_comb begin
        emit_vld   = 1'b0;
        emit_addr  = '0;
        emit_data  = '0;
        push0_vld  = 1'b0;
        push0_addr = '0;
        push0_data = '0;
        push1_vld  = 1'b0;
        push1_addr = '0;
        push1_data = '0;
        if (pop) begin
            emit_vld  = 1'b1;
            emit_addr = q_addr[rd_ptr_r];
            emit_data = q_data[rd_ptr_r];
            if (ld_vld_r) begin
                push0_vld  = 1'b1;
                push0_addr = ld_addr_r;
                push0_data = ld_data;
                push1_vld  = new_vld;
                push1_addr = rd_wr_addr_i;
                push1_data = new_data;
            end else begin
                push0_vld  = new_vld;
                push0_addr = rd_wr_addr_i;
                push0_data = new_data;
            end
        end else if (ld_vld_r) begin
            emit_vld   = 1'b1;
            emit_addr  = ld_addr_r;
            emit_data  = ld_data;
            push0_vld  = new_vld;
            push0_addr = rd_wr_addr_i;
            push0_data = new_data;
        end else if (new_vld) begin
            emit_vld  = 1'b1;
            emit_addr = rd_wr_addr_i;
            emit_data = new_data;
        end
    end

    assign reg_wr_en_o   = ~rst_i & emit_vld;
    assign reg_wr_addr_o = rst_i ? 5'd0 : emit_addr;
    assign reg_wr_data_o = rst_i ? '0 : emit_data;
    assign q_level_o     = rst_i ? '0 : count_r;

    // queue pointers, occupancy and load slot
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_r  <= '0;
            wr_ptr_r  <= '0;
            count_r   <= '0;
            ld_vld_r  <= 1'b0;
            ld_addr_r <= '0;
            ld_sel_r  <= '0;
        end else begin
            rd_ptr_r <= rd_ptr_r + AW'(pop);
            wr_ptr_r <= wr_ptr_r + AW'(push0_vld) + AW'(push1_vld);
            count_r  <= count_r + CW'(push0_vld) + CW'(push1_vld) - CW'(pop);
            ld_vld_r <= ld_take;
            if (ld_take) begin
                ld_addr_r <= rd_wr_addr_i;
                ld_sel_r  <= dram_rd_sel_i;
            end
        end
    end

`ifdef WB_LOAD_ALIGN_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ld_off_r <= '0;
        end else if (ld_take) begin
            ld_off_r <= dram_rd_addr_i[OW-1:0];
        end
    end
`endif

    // queue entry storage; second push lands one slot behind the first
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (push0_vld) begin
                q_addr[wr_ptr_r] <= push0_addr;
                q_data[wr_ptr_r] <= push0_data;
            end
            if (push1_vld) begin
                q_addr[wr_ptr_r + AW'(1)] <= push1_addr;
                q_data[wr_ptr_r + AW'(1)] <= push1_data;
            end
        end
    end

`ifndef SYNTHESIS
    // occupancy can never exceed DEPTH
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (int'(count_r) + int'(push0_vld) + int'(push1_vld) - int'(pop) <= int'(DEPTH));
            assert (!(push0_vld && (count_r == CW'(DEPTH)) && !pop));
        end
    end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Testbench for wb_queue: directed table, reset sequences, then random
// traffic checked against a program-order write-list model.
module tb_wb_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
`ifdef WB_LOAD_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        wb_valid_i;
    logic        wb_stall_o;
    logic        rd_wr_en_i;
    logic [1:0]  rd_wr_sel_i;
    logic [4:0]  rd_wr_addr_i;
    logic [31:0] pc_data_i, alu_data_i;
    logic [2:0]  dram_rd_sel_i;
    logic [31:0] dram_rd_addr_i, dram_rd_data_i;
    logic        reg_wr_en_o;
    logic [4:0]  reg_wr_addr_o;
    logic [31:0] reg_wr_data_o;
    logic [2:0]  q_level_o;

    always #5 clk = ~clk;

    wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .wb_valid_i     (wb_valid_i),
        .wb_stall_o     (wb_stall_o),
        .rd_wr_en_i     (rd_wr_en_i),
        .rd_wr_sel_i    (rd_wr_sel_i),
        .rd_wr_addr_i   (rd_wr_addr_i),
        .pc_data_i      (pc_data_i),
        .alu_data_i     (alu_data_i),
        .dram_rd_sel_i  (dram_rd_sel_i),
        .dram_rd_addr_i (dram_rd_addr_i),
        .dram_rd_data_i (dram_rd_data_i),
        .reg_wr_en_o    (reg_wr_en_o),
        .reg_wr_addr_o  (reg_wr_addr_o),
        .reg_wr_data_o  (reg_wr_data_o),
        .q_level_o      (q_level_o)
    );

    typedef struct {
        bit          rst;
        bit          valid;
        bit          en;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [2:0]  dsel;
        logic [31:0] daddr;
        logic [31:0] ddata;
        bit          e_en;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        int          e_lvl;
        bit          e_stall;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    int n_vec = 0;
    int n_err = 0;

    // model: every pending register write in program order
    wr_t         fifo[$];
    wr_t         nxt[$];
    bit          ld_pend = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [2:0]  ld_sel = '0;
    logic [1:0]  ld_off = '0;
    bit          m_stall, m_take;
    int          m_lvl;

    function automatic vec_t mk(bit rst, bit valid, bit en, logic [1:0] sel, logic [4:0] rd,
                                logic [31:0] pc, logic [31:0] alu, logic [2:0] dsel,
                                logic [31:0] daddr, logic [31:0] ddata,
                                bit e_en, logic [4:0] e_addr, logic [31:0] e_data, int e_lvl);
        vec_t v;
        v.rst = rst; v.valid = valid; v.en = en; v.sel = sel; v.rd = rd;
        v.pc = pc; v.alu = alu; v.dsel = dsel; v.daddr = daddr; v.ddata = ddata;
        v.e_en = e_en; v.e_addr = e_addr; v.e_data = e_data; v.e_lvl = e_lvl;
        v.e_stall = 1'b0;
        return v;
    endfunction

    function automatic logic [31:0] ext(logic [2:0] s, logic [1:0] off, logic [31:0] raw);
        logic [31:0] d;
        d = ALIGN ? (raw >> (8 * int'(off))) : raw;
        case (s)
            3'd0:    return {{24{d[7]}}, d[7:0]};
            3'd1:    return {{16{d[15]}}, d[15:0]};
            3'd2:    return d;
            3'd3:    return {24'd0, d[7:0]};
            3'd4:    return {16'd0, d[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    // this cycle's program-ordered write list: queued, then load return, then new
    function automatic void eval_cycle();
        int  lvl;
        bit  wr;
        wr_t w;
        nxt    = fifo;
        lvl    = fifo.size();
        m_lvl  = rst_i ? 0 : lvl;
        m_stall = !rst_i && ((lvl + (ld_pend ? 1 : 0) - (lvl > 0 ? 1 : 0)) >= int'(DEPTH));
        m_take = 1'b0;
        if (rst_i) begin
            nxt.delete();
            return;
        end
        if (ld_pend) begin
            w.a = ld_rd;
            w.d = ext(ld_sel, ld_off, dram_rd_data_i);
            nxt.push_back(w);
        end
        wr = wb_valid_i && !m_stall && rd_wr_en_i && (rd_wr_addr_i != 5'd0);
        if (wr && rd_wr_sel_i == 2'd3) begin
            m_take = 1'b1;
        end else if (wr) begin
            w.a = rd_wr_addr_i;
            w.d = (rd_wr_sel_i == 2'd0) ? alu_data_i :
                  (rd_wr_sel_i == 2'd1) ? pc_data_i + 32'd4 : pc_data_i + 32'd2;
            nxt.push_back(w);
        end
    endfunction

    function automatic void advance();
        eval_cycle();
        if (nxt.size() > 0) void'(nxt.pop_front());
        fifo    = nxt;
        ld_pend = m_take;
        if (m_take) begin
            ld_rd  = rd_wr_addr_i;
            ld_sel = dram_rd_sel_i;
            ld_off = dram_rd_addr_i[1:0];
        end
    endfunction

    task automatic drive(input vec_t v);
        rst_i          = v.rst;
        wb_valid_i     = v.valid;
        rd_wr_en_i     = v.en;
        rd_wr_sel_i    = v.sel;
        rd_wr_addr_i   = v.rd;
        pc_data_i      = v.pc;
        alu_data_i     = v.alu;
        dram_rd_sel_i  = v.dsel;
        dram_rd_addr_i = v.daddr;
        dram_rd_data_i = v.ddata;
    endtask

    task automatic run(input vec_t v, input string nm, input bit use_model);
        bit          e_en, e_st;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        int          e_l;
        drive(v);
        @(negedge clk);
        eval_cycle();
        if (use_model) begin
            e_en = (nxt.size() > 0);
            e_a  = e_en ? nxt[0].a : 5'd0;
            e_d  = e_en ? nxt[0].d : 32'd0;
            e_l  = m_lvl;
            e_st = m_stall;
        end else begin
            e_en = v.e_en; e_a = v.e_addr; e_d = v.e_data; e_l = v.e_lvl; e_st = v.e_stall;
        end
        n_vec++;
        if (reg_wr_en_o !== e_en || reg_wr_addr_o !== e_a || reg_wr_data_o !== e_d ||
            int'(q_level_o) != e_l || wb_stall_o !== e_st) begin
            n_err++;
            $display("FAIL %s: got en=%0b addr=%0d data=%h lvl=%0d stall=%0b, expected en=%0b addr=%0d data=%h lvl=%0d stall=%0b",
                     nm, reg_wr_en_o, reg_wr_addr_o, reg_wr_data_o, q_level_o, wb_stall_o,
                     e_en, e_a, e_d, e_l, e_st);
        end
        advance();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[20];
    vec_t seq[10];
    vec_t rv;
    logic [31:0] align_exp;

    initial begin
        // sel: 0 ALU, 1 PC+4, 2 PC+2, 3 DRAM; dsel: 0 B, 1 H, 2 W, 3 BU, 4 HU
        tbl[0]  = mk(0,1,1,0, 5, 0, 32'h1234, 0, 0, 0,            1, 5, 32'h1234, 0);
        tbl[1]  = mk(0,1,1,3, 6, 0, 0, 0, 0, 0,                   0, 0, 0, 0);
        tbl[2]  = mk(0,1,1,0, 7, 0, 32'h11, 0, 0, 32'hF0,         1, 6, 32'hFFFFFFF0, 0);
        tbl[3]  = mk(0,0,0,0, 0, 0, 0, 0, 0, 0,                   1, 7, 32'h11, 1);
        tbl[4]  = mk(0,0,0,0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0);
        tbl[5]  = mk(0,1,1,1, 1, 32'hFFFFFFFE, 0, 0, 0, 0,        1, 1, 32'h2, 0);
        tbl[6]  = mk(0,1,1,2, 1, 32'hFFFFFFFE, 0, 0, 0, 0,        1, 1, 32'h0, 0);
        tbl[7]  = mk(0,1,0,0, 3, 0, 32'h33, 0, 0, 0,              0, 0, 0, 0);
        tbl[8]  = mk(0,1,1,0, 0, 0, 32'h44, 0, 0, 0,              0, 0, 0, 0);
        tbl[9]  = mk(0,1,1,3, 0, 0, 0, 2, 0, 0,                   0, 0, 0, 0);
        tbl[10] = mk(0,0,0,0, 0, 0, 0, 0, 0, 32'hDEAD,            0, 0, 0, 0);
        tbl[11] = mk(0,1,1,3, 8, 0, 0, 2, 0, 0,                   0, 0, 0, 0);
        tbl[12] = mk(0,1,0,0, 9, 0, 32'h99, 0, 0, 32'hCAFEBABE,   1, 8, 32'hCAFEBABE, 0);
        tbl[13] = mk(0,1,1,3,10, 0, 0, 1, 0, 0,                   0, 0, 0, 0);
        tbl[14] = mk(0,1,1,3,11, 0, 0, 4, 0, 32'h00008001,        1,10, 32'hFFFF8001, 0);
        tbl[15] = mk(0,1,1,3,12, 0, 0, 3, 0, 32'h000080FF,        1,11, 32'h000080FF, 0);
        tbl[16] = mk(0,0,0,0, 0, 0, 0, 0, 0, 32'h000000FF,        1,12, 32'h000000FF, 0);
        tbl[17] = mk(0,1,1,3,13, 0, 0, 7, 0, 0,                   0, 0, 0, 0);
        tbl[18] = mk(0,1,1,0,14, 0, 32'h5, 0, 0, 32'hFFFF,        1,13, 32'h0, 0);
        tbl[19] = mk(0,0,0,0, 0, 0, 0, 0, 0, 0,                   1,14, 32'h5, 1);

        align_exp = ALIGN ? 32'h0000BEEF : 32'h00000000;
        seq[0] = mk(0,1,1,3,15, 0, 0, 2, 0, 0,                    0, 0, 0, 0);
        seq[1] = mk(0,1,1,0,16, 0, 32'h55, 0, 0, 32'h77,          1,15, 32'h77, 0);
        seq[2] = mk(1,1,1,3,17, 0, 0, 2, 0, 0,                    0, 0, 0, 0);
        seq[3] = mk(0,0,0,0, 0, 0, 0, 0, 0, 32'h99,               0, 0, 0, 0);
        seq[4] = mk(0,1,1,3,18, 0, 0, 2, 0, 0,                    0, 0, 0, 0);
        seq[5] = mk(1,1,1,0,19, 0, 32'h66, 0, 0, 32'h1234,        0, 0, 0, 0);
        seq[6] = mk(0,0,0,0, 0, 0, 0, 0, 0, 32'h4321,             0, 0, 0, 0);
        seq[7] = mk(0,1,1,0,20, 0, 32'hAB, 0, 0, 0,               1,20, 32'hAB, 0);
        seq[8] = mk(0,1,1,3,21, 0, 0, 4, 32'h102, 0,              0, 0, 0, 0);
        seq[9] = mk(0,0,0,0, 0, 0, 0, 0, 0, 32'hBEEF0000,         1,21, align_exp, 0);

        run(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0), "reset0", 1'b0);
        run(mk(1,1,1,0,5,0,32'h7,0,0,0, 0,0,0,0), "reset1", 1'b0);

        for (int i = 0; i < 20; i++) run(tbl[i], $sformatf("tbl[%0d]", i), 1'b0);

        // reset with a queued write, then with a load in flight; LHU at offset 2
        for (int i = 0; i < 10; i++) run(seq[i], $sformatf("seq[%0d]", i), 1'b0);

        for (int i = 0; i < 3000; i++) begin
            rv = mk(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8),
                    ($urandom_range(0, 9) < 9), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 19) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    $urandom, $urandom, 3'($urandom_range(0, 7)), $urandom, $urandom,
                    0, 0, 0, 0);
            run(rv, $sformatf("rand[%0d]", i), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
